// File: rtl/lvds_link_tester.sv
// Multi-lane LVDS loopback tester: rotating-pattern TX, latency search and per-lane error counting.
// Optional error injection (input err_inject) is enabled by defining LVDS_ERR_INJECT_EN.
module lvds_link_tester #(
    parameter int LANES     = 2,
    parameter int PATTERN_W = 8,
    parameter int DIV       = 5,
    parameter int MAX_LAT   = 8,
    parameter int ERR_W     = 16
) (
    input  logic                   clk_in,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic [PATTERN_W-1:0]   pattern,
    input  logic                   clear_err,
    output logic [LANES-1:0]       tx_bit,
    input  logic [LANES-1:0]       rx_bit,
    output logic                   bit_tick,
    output logic [LANES-1:0]       locked,
    output logic [LANES*ERR_W-1:0] err_count
`ifdef LVDS_ERR_INJECT_EN
    ,
    input  logic [LANES-1:0]       err_inject
`endif
);

    localparam int CNT_W  = $clog2(DIV);
    localparam int HIST_D = MAX_LAT + 2;
    localparam int OFF_W  = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam int TAP_W  = $clog2(HIST_D);
    localparam int RUN_W  = $clog2(2 * PATTERN_W);

    typedef enum logic {ST_SEARCH = 1'b0, ST_LOCKED = 1'b1} lane_state_t;

    logic [CNT_W-1:0]     div_cnt;
    logic                 sample_en;
    logic [PATTERN_W-1:0] sr;
    logic [LANES-1:0]     tx_raw;
    logic [LANES-1:0]     tx_inv;
    logic [LANES-1:0]     rx_s1, rx_s2;

    // NOTE: every clocked block uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk_in) begin
        if (!reset_n || !enable)
            div_cnt <= '0;
        else if (div_cnt == CNT_W'(DIV - 1))
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + 1'b1;
    end

    assign bit_tick  = enable && (div_cnt == CNT_W'(DIV - 1));
    assign sample_en = enable && (div_cnt == CNT_W'(DIV / 2));

    always_ff @(posedge clk_in) begin
        if (!reset_n || !enable)
            sr <= pattern;
        else if (bit_tick)
            sr <= (sr << 1) | (sr >> (PATTERN_W - 1));
    end

`ifdef LVDS_ERR_INJECT_EN
    logic [LANES-1:0] inj_pend, inj_act;

    // A request waits for the next bit boundary, then inverts one whole bit.
    always_ff @(posedge clk_in) begin
        if (!reset_n || !enable) begin
            inj_pend <= '0;
            inj_act  <= '0;
        end else if (bit_tick) begin
            inj_act  <= inj_pend;
            inj_pend <= err_inject & ~inj_pend & ~inj_act;
        end else begin
            inj_pend <= inj_pend | (err_inject & ~inj_act);
        end
    end

    assign tx_inv = inj_act;
`else
    assign tx_inv = '0;
`endif

    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            tx_bit <= '0;
            rx_s1  <= '0;
            rx_s2  <= '0;
        end else begin
            tx_bit <= tx_raw ^ tx_inv;
            rx_s1  <= rx_bit;
            rx_s2  <= rx_s1;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        localparam int POS   = PATTERN_W - 1 - (i % PATTERN_W);
        // Push the bit three periods ahead so tap 2 is the bit on the wire now.
        localparam int AHEAD = (POS + 3 * PATTERN_W - 3) % PATTERN_W;

        logic [HIST_D-1:0] hist;
        lane_state_t       state, state_n;
        logic [RUN_W-1:0]  run, run_n;
        logic [OFF_W-1:0]  offset, offset_n;
        logic [1:0]        miss, miss_n;
        logic [ERR_W-1:0]  err, err_n;
        logic [TAP_W-1:0]  tap;
        logic              match;

        assign tx_raw[i] = sr[POS];
        assign tap       = TAP_W'(offset) + TAP_W'(2);
        assign match     = (rx_s2[i] == hist[tap]);

        // NOTE: the history is a short shift register, so it is reset with the rest of the lane.
        always_ff @(posedge clk_in) begin
            if (!reset_n)
                hist <= '0;
            else if (bit_tick)
                hist <= {hist[HIST_D-2:0], sr[AHEAD]};
        end

        always_ff @(posedge clk_in) begin
            if (!reset_n) begin
                state  <= ST_SEARCH;
                run    <= '0;
                offset <= '0;
                miss   <= '0;
                err    <= '0;
            end else begin
                state  <= state_n;
                run    <= run_n;
                offset <= offset_n;
                miss   <= miss_n;
                err    <= err_n;
            end
        end

        always_comb begin
            // NOTE: hold-current defaults first, so no path through this block infers a latch.
            state_n  = state;
            run_n    = run;
            offset_n = offset;
            miss_n   = miss;
            err_n    = err;
            if (!enable) begin
                state_n = ST_SEARCH;
                run_n   = '0;
                miss_n  = '0;
            end else if (sample_en) begin
                case (state)
                    ST_SEARCH: begin
                        if (match) begin
                            if (run == RUN_W'(2 * PATTERN_W - 1)) begin
                                state_n = ST_LOCKED;
                                run_n   = '0;
                                miss_n  = '0;
                            end else begin
                                run_n = run + 1'b1;
                            end
                        end else begin
                            run_n    = '0;
                            offset_n = (offset == OFF_W'(MAX_LAT - 1)) ? '0 : offset + 1'b1;
                        end
                    end
                    ST_LOCKED: begin
                        if (match) begin
                            miss_n = '0;
                        end else begin
                            if (err != {ERR_W{1'b1}})
                                err_n = err + 1'b1;
                            if (miss == 2'd3) begin
                                state_n = ST_SEARCH;
                                run_n   = '0;
                                miss_n  = '0;
                            end else begin
                                miss_n = miss + 1'b1;
                            end
                        end
                    end
                    default: state_n = ST_SEARCH;
                endcase
            end
            if (clear_err)
                err_n = '0;
        end

        assign locked[i]                  = (state == ST_LOCKED);
        assign err_count[i*ERR_W +: ERR_W] = err;
    end

endmodule
